// File: rtl/pri.sv
// Priority selector: one-hot of the highest-index set request bit.
module pri #(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);

    always_comb begin
        gnt = '0;
        for (int i = 0; i < W; i++) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pend_sel.sv
// Sticky request collector; issues the highest pending requester as a
// registered one-hot grant with encoded index under a valid/ack handshake.
module pend_sel #(
    parameter int W = 8,
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [W-1:0]  i_req,
    input  logic          i_flush,
    input  logic          i_gnt_ack,
    output logic [W-1:0]  o_pend,
    output logic          o_gnt_vld,
    output logic [W-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t        state_r, state_nx;
    logic [W-1:0]  pend_r, pend_nx;
    logic [W-1:0]  gnt_r, gnt_nx;
    logic [IW-1:0] gnt_idx_r, gnt_idx_nx;
    logic [W-1:0]  sel;
    logic [IW-1:0] sel_idx;
    logic          load;

    pri #(.W(W)) u_pri (
        .req (pend_r),
        .gnt (sel)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (sel[i]) sel_idx = sel_idx | IW'(i);
        end
    end

    assign load = !i_flush && (pend_r != '0) &&
                  ((state_r == EMPTY) || i_gnt_ack);

    always_comb begin
        state_nx   = state_r;
        gnt_nx     = gnt_r;
        gnt_idx_nx = gnt_idx_r;
        pend_nx    = (pend_r & ~(load ? sel : '0)) | i_req;
        if (i_flush) begin
            state_nx   = EMPTY;
            gnt_nx     = '0;
            gnt_idx_nx = '0;
            pend_nx    = '0;
        end else if (load) begin
            state_nx   = HELD;
            gnt_nx     = sel;
            gnt_idx_nx = sel_idx;
        end else if (state_r == HELD && i_gnt_ack) begin
            state_nx   = EMPTY;
            gnt_nx     = '0;
            gnt_idx_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r   <= EMPTY;
            pend_r    <= '0;
            gnt_r     <= '0;
            gnt_idx_r <= '0;
        end else begin
            state_r   <= state_nx;
            pend_r    <= pend_nx;
            gnt_r     <= gnt_nx;
            gnt_idx_r <= gnt_idx_nx;
        end
    end

    assign o_pend    = pend_r;
    assign o_gnt_vld = (state_r == HELD);
    assign o_gnt     = gnt_r;
    assign o_gnt_idx = gnt_idx_r;

    a_onehot : assert property (@(posedge clk) disable iff (arst)
        $onehot0(o_gnt));
    a_vld : assert property (@(posedge clk) disable iff (arst)
        o_gnt_vld == (|o_gnt));
    a_stable : assert property (@(posedge clk) disable iff (arst)
        (o_gnt_vld && !i_gnt_ack && !i_flush) |=>
        ($stable(o_gnt) && $stable(o_gnt_idx)));

endmodule

// File: tb/tb_pend_sel.sv
// Directed table plus randomized model check for pend_sel (W=8 and W=1).
module tb_pend_sel;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] req = '0;
    logic       flush = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] pend;
    logic       vld;
    logic [7:0] gnt;
    logic [2:0] idx;

    logic r1_req = 1'b0;
    logic r1_ack = 1'b0;
    logic r1_pend, r1_vld, r1_gnt, r1_idx;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_pend;
    int         m_idx;

    always #5 clk = ~clk;

    pend_sel #(.W(8)) dut (
        .clk       (clk),
        .arst      (arst),
        .i_req     (req),
        .i_flush   (flush),
        .i_gnt_ack (ack),
        .o_pend    (pend),
        .o_gnt_vld (vld),
        .o_gnt     (gnt),
        .o_gnt_idx (idx)
    );

    pend_sel #(.W(1)) dut1 (
        .clk       (clk),
        .arst      (arst),
        .i_req     (r1_req),
        .i_flush   (1'b0),
        .i_gnt_ack (r1_ack),
        .o_pend    (r1_pend),
        .o_gnt_vld (r1_vld),
        .o_gnt     (r1_gnt),
        .o_gnt_idx (r1_idx)
    );

    typedef struct {
        logic [7:0] req;
        logic       flush;
        logic       ack;
        logic [7:0] e_pend;
        logic       e_vld;
        logic [7:0] e_gnt;
        logic [2:0] e_idx;
    } vec_t;

    vec_t tv[21];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pending set of requester numbers and the granted number.
    task automatic model_update();
        int hi;
        bit ld;
        hi = -1;
        for (int k = 7; k >= 0; k--)
            if (m_pend[k] && hi < 0) hi = k;
        ld = !flush && hi >= 0 && (m_idx < 0 || ack);
        if (flush) begin
            m_pend = '0;
            m_idx  = -1;
        end else begin
            if (ld) begin
                m_pend[hi] = 1'b0;
                m_idx      = hi;
            end else if (ack) begin
                m_idx = -1;
            end
            m_pend = m_pend | req;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] eg;
        eg = (m_idx < 0) ? 8'h00 : 8'(1 << m_idx);
        chk({tag, "_pend"}, 64'(pend), 64'(m_pend));
        chk({tag, "_vld"}, 64'(vld), 64'(m_idx >= 0));
        chk({tag, "_gnt"}, 64'(gnt), 64'(eg));
        chk({tag, "_idx"}, 64'(idx), (m_idx < 0) ? 64'd0 : 64'(m_idx));
    endtask

    task automatic do_reset();
        arst = 1'b1;
        req = '0; flush = 0; ack = 0; r1_req = 0; r1_ack = 0;
        m_pend = '0;
        m_idx = -1;
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
        #1;
    endtask

    initial begin
        //          req    fl ack  pend   vld gnt    idx
        tv[0]  = '{8'h25, 0, 1, 8'h25, 0, 8'h00, 3'd0};
        tv[1]  = '{8'h00, 0, 1, 8'h05, 1, 8'h20, 3'd5};
        tv[2]  = '{8'h00, 0, 1, 8'h01, 1, 8'h04, 3'd2};
        tv[3]  = '{8'h00, 0, 1, 8'h00, 1, 8'h01, 3'd0};
        tv[4]  = '{8'h00, 0, 1, 8'h00, 0, 8'h00, 3'd0};
        tv[5]  = '{8'h81, 0, 0, 8'h81, 0, 8'h00, 3'd0};
        tv[6]  = '{8'h00, 0, 0, 8'h01, 1, 8'h80, 3'd7};
        tv[7]  = '{8'h00, 0, 0, 8'h01, 1, 8'h80, 3'd7};
        tv[8]  = '{8'h00, 0, 0, 8'h01, 1, 8'h80, 3'd7};
        tv[9]  = '{8'h00, 0, 0, 8'h01, 1, 8'h80, 3'd7};
        tv[10] = '{8'h00, 0, 0, 8'h01, 1, 8'h80, 3'd7};
        tv[11] = '{8'h00, 0, 1, 8'h00, 1, 8'h01, 3'd0};
        tv[12] = '{8'h00, 0, 1, 8'h00, 0, 8'h00, 3'd0};
        tv[13] = '{8'h08, 0, 0, 8'h08, 0, 8'h00, 3'd0};
        tv[14] = '{8'h08, 0, 0, 8'h08, 1, 8'h08, 3'd3};
        tv[15] = '{8'h00, 0, 1, 8'h00, 1, 8'h08, 3'd3};
        tv[16] = '{8'h00, 0, 1, 8'h00, 0, 8'h00, 3'd0};
        tv[17] = '{8'h10, 0, 0, 8'h10, 0, 8'h00, 3'd0};
        tv[18] = '{8'h00, 0, 0, 8'h00, 1, 8'h10, 3'd4};
        tv[19] = '{8'hFF, 1, 1, 8'h00, 0, 8'h00, 3'd0};
        tv[20] = '{8'h00, 0, 0, 8'h00, 0, 8'h00, 3'd0};

        #3;
        chk("rst_pend", 64'(pend), 64'd0);
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        do_reset();

        for (int i = 0; i < 21; i++) begin
            req = tv[i].req;
            flush = tv[i].flush;
            ack = tv[i].ack;
            step();
            chk($sformatf("tv%0d_pend", i), 64'(pend), 64'(tv[i].e_pend));
            chk($sformatf("tv%0d_vld", i), 64'(vld), 64'(tv[i].e_vld));
            chk($sformatf("tv%0d_gnt", i), 64'(gnt), 64'(tv[i].e_gnt));
            chk($sformatf("tv%0d_idx", i), 64'(idx), 64'(tv[i].e_idx));
        end

        do_reset();
        for (int i = 0; i < 400; i++) begin
            req = 8'($urandom & $urandom & $urandom);
            flush = ($urandom_range(0, 15) == 0);
            ack = $urandom_range(0, 1) == 1;
            step();
            chk_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset while 8'h10 is held.
        do_reset();
        req = 8'h10;
        step();
        req = 8'h00;
        step();
        chk("pre_arst_gnt", 64'(gnt), 64'h10);
        #2 arst = 1'b1;
        #1;
        chk("arst_pend", 64'(pend), 64'd0);
        chk("arst_vld", 64'(vld), 64'd0);
        chk("arst_gnt", 64'(gnt), 64'd0);
        chk("arst_idx", 64'(idx), 64'd0);
        m_pend = '0;
        m_idx = -1;
        @(posedge clk);
        #2 arst = 1'b0;
        repeat (3) step();
        chk_model("post_arst");
        chk("post_arst_vld", 64'(vld), 64'd0);

        // W=1 instance.
        r1_req = 1'b1;
        @(posedge clk); #1;
        r1_req = 1'b0;
        chk("w1_pend", 64'(r1_pend), 64'd1);
        chk("w1_vld0", 64'(r1_vld), 64'd0);
        @(posedge clk); #1;
        chk("w1_vld", 64'(r1_vld), 64'd1);
        chk("w1_gnt", 64'(r1_gnt), 64'd1);
        chk("w1_idx", 64'(r1_idx), 64'd0);
        r1_ack = 1'b1;
        @(posedge clk); #1;
        r1_ack = 1'b0;
        chk("w1_ack_vld", 64'(r1_vld), 64'd0);
        chk("w1_ack_gnt", 64'(r1_gnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
